// File: rtl/play_sequencer.sv
// play_sequencer: PLAY-phase sequencer for the rhythm game.
// This module steps through the selected song's note ROM one beat at a time.
// Each beat opens a hit window, judges button pulses against the pending lanes,
// keeps a saturating score, and raises finish when the song ends.
// Optional feature macro: COMBO_BONUS_EN.
//   When defined, the module adds a 4-bit combo output. While combo >= 8,
//   each hit scores double.
//
// state  | meaning
// IDLE   | waiting for a valid start
// FETCH  | two cycles: the ROM address is presented, then the lane mask is loaded
// BEAT   | tick runs 0..BEAT_TICKS-1; hits are judged while tick < HIT_WIN
// DONE   | song complete; finish stays high until a valid start arrives
module play_sequencer #(
  parameter int BEAT_TICKS = 25_000_000,
  parameter int HIT_WIN    = 5_000_000,
  parameter int SONG_LEN   = 64,
  parameter int SCORE_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         song_id,
  input  logic [2:0]         btn_pulse,
  output logic [7:0]         rom_addr,
  input  logic [2:0]         rom_data,
  output logic [2:0]         note_lanes,
  output logic [SCORE_W-1:0] score,
  output logic               hit,
  output logic               miss,
  output logic               busy,
  output logic               finish
`ifdef COMBO_BONUS_EN
  ,
  output logic [3:0]         combo
`endif
);

  localparam int TICK_W = $clog2(BEAT_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_BEAT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q;
  logic               fetch_q;
  logic [5:0]         beat_idx_q;
  logic [1:0]         song_q;
  logic               accept_start, fetch_done, beat_end, last_beat;
  logic [2:0]         acc;
  logic [1:0]         pop;
  logic [2:0]         inc;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
`ifdef COMBO_BONUS_EN
  logic               had_lanes_q;
`endif

  assign rom_addr  = {song_q, beat_idx_q};
  assign busy      = (state_q == S_FETCH) || (state_q == S_BEAT);
  assign finish    = (state_q == S_DONE);
  assign last_beat = (beat_idx_q == 6'(SONG_LEN - 1));

  // Next-state logic and control strobes. Abort overrides every transition.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    fetch_done   = 1'b0;
    beat_end     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && song_id != 2'd0) begin
          accept_start = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_q) begin
          fetch_done = 1'b1;
          state_d    = S_BEAT;
        end
      end
      S_BEAT: begin
        if (tick_q == TICK_W'(BEAT_TICKS - 1)) begin
          beat_end = 1'b1;
          state_d  = last_beat ? S_DONE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d      = S_IDLE;
      accept_start = 1'b0;
      fetch_done   = 1'b0;
      beat_end     = 1'b0;
    end
  end

  // Hit judging: find the accepted lanes, compute the score increment, and saturate the new score.
  always_comb begin
    acc = 3'b000;
    if (state_q == S_BEAT && tick_q < TICK_W'(HIT_WIN) && !abort)
      acc = btn_pulse & note_lanes;
    pop = 2'(acc[0]) + 2'(acc[1]) + 2'(acc[2]);
`ifdef COMBO_BONUS_EN
    inc = (combo >= 4'd8) ? {pop, 1'b0} : {1'b0, pop};
`else
    inc = {1'b0, pop};
`endif
    score_sum = {1'b0, score} + (SCORE_W + 1)'(inc);
    score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath: fetch sequencing, beat timer, lane bookkeeping, score and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= '0;
      fetch_q     <= 1'b0;
      beat_idx_q  <= '0;
      song_q      <= '0;
      note_lanes  <= '0;
      score       <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
`ifdef COMBO_BONUS_EN
      combo       <= '0;
      had_lanes_q <= 1'b0;
`endif
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (abort) begin
        note_lanes <= '0;
        tick_q     <= '0;
        fetch_q    <= 1'b0;
`ifdef COMBO_BONUS_EN
        combo      <= '0;
`endif
      end else begin
        if (accept_start) begin
          song_q     <= song_id;
          beat_idx_q <= '0;
          score      <= '0;
          fetch_q    <= 1'b0;
`ifdef COMBO_BONUS_EN
          combo      <= '0;
`endif
        end
        if (state_q == S_FETCH) begin
          fetch_q <= ~fetch_q;
          if (fetch_done) begin
            note_lanes  <= rom_data;
            tick_q      <= '0;
`ifdef COMBO_BONUS_EN
            had_lanes_q <= |rom_data;
`endif
          end
        end
        if (state_q == S_BEAT) begin
          tick_q <= tick_q + 1'b1;
          if (acc != 3'b000) begin
            hit        <= 1'b1;
            score      <= score_sat;
            note_lanes <= note_lanes & ~acc;
          end
          if (beat_end) begin
            tick_q     <= '0;
            note_lanes <= '0;
            miss       <= |note_lanes;
            if (!last_beat) beat_idx_q <= beat_idx_q + 1'b1;
`ifdef COMBO_BONUS_EN
            if (|note_lanes)                    combo <= '0;
            else if (had_lanes_q && combo != 4'hf) combo <= combo + 1'b1;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_play_sequencer.sv
// tb_play_sequencer: directed, table-driven bench for play_sequencer.
// The bench uses a small note ROM with registered reads, a 16-tick beat, a 4-tick hit window and 4-beat songs.
module tb_play_sequencer;
  localparam int BT = 16;
  localparam int HW = 4;
  localparam int SL = 4;
  localparam int SW = 10;

  logic          clk, rst, start, abort;
  logic [1:0]    song_id;
  logic [2:0]    btn_pulse;
  logic [7:0]    rom_addr;
  logic [2:0]    rom_data;
  logic [2:0]    note_lanes;
  logic [SW-1:0] score;
  logic          hit, miss, busy, finish;
`ifdef COMBO_BONUS_EN
  logic [3:0]    combo;
`endif

  play_sequencer #(.BEAT_TICKS(BT), .HIT_WIN(HW), .SONG_LEN(SL), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .song_id(song_id),
    .btn_pulse(btn_pulse), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_lanes(note_lanes), .score(score), .hit(hit), .miss(miss),
    .busy(busy), .finish(finish)
`ifdef COMBO_BONUS_EN
    , .combo(combo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rom_mem [0:255];
  initial begin
    for (int a = 0; a < 256; a++) rom_mem[a] = 3'b000;
    rom_mem[8'h40] = 3'b001; rom_mem[8'h41] = 3'b011; rom_mem[8'h42] = 3'b000; rom_mem[8'h43] = 3'b111;
    rom_mem[8'h80] = 3'b111; rom_mem[8'h81] = 3'b101; rom_mem[8'h82] = 3'b010; rom_mem[8'h83] = 3'b100;
  end
  // Registered ROM read, one cycle of latency.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         song;
    int         beat;
    logic [2:0] press;
    int         ptick;
    logic [2:0] lanes_beat;
    int         hits;
    int         misses;
    logic [2:0] lanes_end;
    int         score_end;
  } vec_t;

  vec_t vecs [9];

  // One beat: start the song if this is beat 0, then run all BT ticks with one press, then do the fetch.
  task automatic run_vec(input int i);
    vec_t v;
    int h, m;
    v = vecs[i];
    h = 0;
    m = 0;
    if (v.beat == 0) begin
      start = 1'b1; song_id = 2'(v.song);
      step();
      start = 1'b0; song_id = 2'd0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("finish_cleared", 32'(finish), 32'd0);
      check("score_cleared", 32'(score), 32'd0);
      step();
      check("lanes_not_yet", 32'(note_lanes), 32'd0);
      step();
    end
    check("beat_lanes", 32'(note_lanes), 32'(v.lanes_beat));
    check("rom_addr", 32'(rom_addr), 32'(v.song * 64 + v.beat));
    for (int t = 0; t < BT; t++) begin
      btn_pulse = (t == v.ptick) ? v.press : 3'b000;
      step();
      btn_pulse = 3'b000;
      if (hit) h++;
      if (miss) m++;
      if (t == BT - 2) check("lanes_before_end", 32'(note_lanes), 32'(v.lanes_end));
    end
    check("hit_count", 32'(h), 32'(v.hits));
    check("miss_count", 32'(m), 32'(v.misses));
    check("score_end", 32'(score), 32'(v.score_end));
    check("lanes_cleared", 32'(note_lanes), 32'd0);
    if (v.beat == SL - 1) begin
      check("finish_set", 32'(finish), 32'd1);
      check("busy_done", 32'(busy), 32'd0);
    end else begin
      check("busy_fetch", 32'(busy), 32'd1);
      step();
      step();
    end
  endtask

  initial begin
    //         song beat press  ptick lanes  hits miss lanes_end score
    vecs[0] = '{1, 0, 3'b001, 2, 3'b001, 1, 0, 3'b000, 1};
    vecs[1] = '{1, 1, 3'b011, 0, 3'b011, 1, 0, 3'b000, 3};
    vecs[2] = '{1, 2, 3'b100, 1, 3'b000, 0, 0, 3'b000, 3};
    vecs[3] = '{1, 3, 3'b000, 0, 3'b111, 0, 1, 3'b111, 3};
    vecs[4] = '{2, 0, 3'b101, 3, 3'b111, 1, 1, 3'b010, 2};
    vecs[5] = '{2, 1, 3'b111, 1, 3'b101, 1, 0, 3'b000, 4};
    vecs[6] = '{2, 2, 3'b010, 4, 3'b010, 0, 1, 3'b010, 4};
    vecs[7] = '{2, 3, 3'b100, 0, 3'b100, 1, 0, 3'b000, 5};
    vecs[8] = '{1, 0, 3'b001, 4, 3'b001, 0, 1, 3'b001, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; song_id = 2'd0; btn_pulse = 3'b000;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_lanes", 32'(note_lanes), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_hit_miss", 32'({hit, miss}), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) run_vec(i);

    // A start with song_id 0 while in DONE must be ignored.
    start = 1'b1; song_id = 2'd0;
    step();
    start = 1'b0;
    step();
    check("id0_finish_held", 32'(finish), 32'd1);
    check("id0_busy", 32'(busy), 32'd0);
    check("id0_score_held", 32'(score), 32'd3);

    for (int i = 4; i < 9; i++) run_vec(i);

    // Beat 1 of song 1: score one lane, ignore a start while busy, then abort together with start.
    btn_pulse = 3'b010;
    step();
    btn_pulse = 3'b000;
    check("b1_hit", 32'(hit), 32'd1);
    check("b1_score", 32'(score), 32'd1);
    check("b1_lanes", 32'(note_lanes), 32'b001);
    step();
    start = 1'b1; song_id = 2'd3;
    step();
    start = 1'b0; song_id = 2'd0;
    check("busy_start_ignored", 32'(rom_addr), 32'h41);
    step();
    step();
    abort = 1'b1; start = 1'b1; song_id = 2'd2;
    step();
    abort = 1'b0; start = 1'b0; song_id = 2'd0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_finish", 32'(finish), 32'd0);
    check("abort_lanes", 32'(note_lanes), 32'd0);
    check("abort_score_held", 32'(score), 32'd1);
    step();
    step();
    check("abort_wins", 32'(busy), 32'd0);

    // Reset in the middle of a song must restore the power-on state.
    start = 1'b1; song_id = 2'd2;
    step();
    start = 1'b0; song_id = 2'd0;
    step();
    step();
    btn_pulse = 3'b111;
    step();
    btn_pulse = 3'b000;
    check("pre_rst_score", 32'(score), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_score", 32'(score), 32'd0);
    check("midrst_lanes", 32'(note_lanes), 32'd0);
    check("midrst_rom_addr", 32'(rom_addr), 32'd0);
    check("midrst_hit", 32'(hit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
